// File: rtl/interrupt_sequencer_pkg.sv
// Shared types for the interrupt sequencer: FSM encoding,
// drain default, CCR bit positions and the per-state strobe decode.
package interrupt_sequencer_pkg;

    localparam int DRAIN_DEFAULT = 3;

    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [3:0] {
        IDLE,
        DRAIN,
        PUSH_HI,
        PUSH_LO,
        PUSH_FLG,
        VECTOR,
        POP_FLG,
        POP_LO,
        POP_HI,
        RETURN
    } state_t;

    typedef struct packed {
        logic busy;
        logic stall;
        logic we;
        logic re;
        logic spWen;
        logic flagsWen;
        logic intRedirect;
        logic jump;
    } ctl_t;

    function automatic ctl_t ctlOf(state_t s);
        ctl_t c;
        c = '0;
        c.busy = (s != IDLE);
        c.we = s inside {PUSH_HI, PUSH_LO, PUSH_FLG};
        c.re = s inside {POP_FLG, POP_LO, POP_HI};
        c.stall = c.we | c.re | (s == DRAIN);
        c.spWen = c.we | c.re;
        c.flagsWen = (s == POP_FLG);
        c.intRedirect = (s == VECTOR);
        c.jump = (s == RETURN);
        return c;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Fetch-redirect and data-stack port bundle of the interrupt sequencer.
// master = the sequencer, slave = fetch/execute/data-memory side.
interface interrupt_sequencer_if #(
    parameter int PC_W = 32
);
    logic            int_req;
    logic            imm_pending;
    logic [PC_W-1:0] fetch_pc;
    logic            ex_jump;
    logic [PC_W-1:0] ex_target;
    logic [2:0]      flags_in;
    logic            rti_req;
    logic [PC_W-1:0] sp_in;
    logic [15:0]     mem_rdata;
    logic            fetch_stall;
    logic            int_redirect;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            mem_we;
    logic            mem_re;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_wdata;
    logic            sp_wen;
    logic [PC_W-1:0] sp_out;
    logic            flags_wen;
    logic [2:0]      flags_out;
    logic            busy;

    modport master (
        input  int_req, imm_pending, fetch_pc, ex_jump, ex_target,
        input  flags_in, rti_req, sp_in, mem_rdata,
        output fetch_stall, int_redirect, jump, jump_target,
        output mem_we, mem_re, mem_addr, mem_wdata,
        output sp_wen, sp_out, flags_wen, flags_out, busy
    );

    modport slave (
        output int_req, imm_pending, fetch_pc, ex_jump, ex_target,
        output flags_in, rti_req, sp_in, mem_rdata,
        input  fetch_stall, int_redirect, jump, jump_target,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        input  sp_wen, sp_out, flags_wen, flags_out, busy
    );
endinterface

// File: rtl/interrupt_sequencer_int_pending_latch.sv
// Rising-edge detector on int_req plus the single-level pending flag.
// Clear dominates, so an edge landing in VECTOR is dropped.
module int_pending_latch (
    input  logic clk,
    input  logic rst,
    input  logic intReq,
    input  logic clr,
    output logic pending
);
    logic intReqQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intReqQ <= 1'b0;
            pending <= 1'b0;
        end else begin
            intReqQ <= intReq;
            if (clr)
                pending <= 1'b0;
            else if (intReq && !intReqQ)
                pending <= 1'b1;
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry (drain, 3-word push, vector) and RTI exit
// (3-word pop, return jump) sequencer driving fetch redirects.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_DEFAULT,
    parameter int PC_W = 32
) (
    input logic clk,
    input logic rst,
    interrupt_sequencer_if.master bus
);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    state_t          state;
    state_t          nxt;
    ctl_t            ctl;
    logic [CW-1:0]   cnt;
    logic [PC_W-1:0] retPc;
    logic            pending;
    logic [PC_W-1:0] spDec;
    logic [PC_W-1:0] spInc;

    int_pending_latch uPending (
        .clk     (clk),
        .rst     (rst),
        .intReq  (bus.int_req),
        .clr     (state == VECTOR),
        .pending (pending)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.rti_req)
                    nxt = POP_FLG;
                else if (pending && !bus.imm_pending)
                    nxt = DRAIN;
            end
            DRAIN:    if (cnt == LAST) nxt = PUSH_HI;
            PUSH_HI:  nxt = PUSH_LO;
            PUSH_LO:  nxt = PUSH_FLG;
            PUSH_FLG: nxt = VECTOR;
            VECTOR:   nxt = IDLE;
            POP_FLG:  nxt = POP_LO;
            POP_LO:   nxt = POP_HI;
            POP_HI:   nxt = RETURN;
            RETURN:   nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctl   <= '0;
            cnt   <= '0;
            retPc <= '0;
        end else begin
            state <= nxt;
            ctl   <= ctlOf(nxt);
            if (state == IDLE && nxt == DRAIN) begin
                retPc <= bus.fetch_pc;
                cnt   <= '0;
            end
            if (state == DRAIN) begin
                cnt <= cnt + CW'(1);
                if (bus.ex_jump)
                    retPc <= bus.ex_target;
            end
            if (state == POP_LO)
                retPc[15:0] <= bus.mem_rdata;
            if (state == POP_HI)
                retPc[PC_W-1:16] <= bus.mem_rdata;
        end
    end

    assign spDec = bus.sp_in - PC_W'(1);
    assign spInc = bus.sp_in + PC_W'(1);

    assign bus.busy         = ctl.busy;
    assign bus.fetch_stall  = ctl.stall;
    assign bus.mem_we       = ctl.we;
    assign bus.mem_re       = ctl.re;
    assign bus.sp_wen       = ctl.spWen;
    assign bus.flags_wen    = ctl.flagsWen;
    assign bus.int_redirect = ctl.intRedirect;
    assign bus.jump         = ctl.jump;

    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.sp_out      = '0;
        bus.flags_out   = '0;
        bus.jump_target = '0;
        unique case (state)
            PUSH_HI: begin
                bus.mem_addr  = bus.sp_in;
                bus.sp_out    = spDec;
                bus.mem_wdata = retPc[PC_W-1:16];
            end
            PUSH_LO: begin
                bus.mem_addr  = bus.sp_in;
                bus.sp_out    = spDec;
                bus.mem_wdata = retPc[15:0];
            end
            PUSH_FLG: begin
                bus.mem_addr  = bus.sp_in;
                bus.sp_out    = spDec;
                bus.mem_wdata = {13'b0, bus.flags_in};
            end
            POP_FLG: begin
                bus.mem_addr  = spInc;
                bus.sp_out    = spInc;
                bus.flags_out = bus.mem_rdata[2:0];
            end
            POP_LO, POP_HI: begin
                bus.mem_addr = spInc;
                bus.sp_out   = spInc;
            end
            RETURN:  bus.jump_target = retPc;
            default: ;
        endcase
    end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Control block that drives the redirect side of the fetch stage: it turns an external interrupt request into a pipeline drain, a three-word context push to the data stack, and a one-cycle interrupt redirect into fetch. It also runs the matching RTI context pop and the return jump. It sits beside fetch and the data memory port, and produces the stall, interrupt and jump controls that fetch consumes.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of stall cycles spent flushing in-flight instructions before the push.
- PC_W, 32, program counter width; always two 16-bit memory words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- int_req  in  1  external interrupt request; rising edge is latched
- imm_pending  in  1  fetch is between the two words of a 32-bit instruction; entry is deferred while high
- fetch_pc  in  32  current fetch PC; captured as the return address
- ex_jump  in  1  branch resolved in execute
- ex_target  in  32  branch target for ex_jump
- flags_in  in  3  CCR {C,N,Z} to save
- rti_req  in  1  RTI decoded in execute, one-cycle pulse
- sp_in  in  32  current stack pointer
- mem_rdata  in  16  data memory read data, combinational on mem_addr
- fetch_stall  out  1  hold fetch PC
- int_redirect  out  1  interrupt redirect into fetch
- jump  out  1  jump redirect into fetch
- jump_target  out  32  target for jump
- mem_we, mem_re  out  1  data memory write and read strobes
- mem_addr  out  32  data memory address
- mem_wdata  out  16  data memory write data
- sp_wen  out  1  stack pointer write enable
- sp_out  out  32  new stack pointer value
- flags_wen  out  1  restore the CCR
- flags_out  out  3  restored flags
- busy  out  1  FSM is not in IDLE

## Operation
- pending is set on the clk edge after int_req goes 0→1.
  - pending clears only in VECTOR or on reset.
  - Further edges while pending is set are ignored (single level, no nesting).
- FSM states: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR, POP_FLG, POP_LO, POP_HI, RETURN.
- Transitions out of IDLE:
  - IDLE→POP_FLG when rti_req. RTI wins over a simultaneous pending.
  - IDLE→DRAIN when pending && !imm_pending.
- On entry to DRAIN, ret_pc is loaded from fetch_pc.
  - During DRAIN, ex_jump=1 overwrites ret_pc with ex_target. The last one wins.
- DRAIN counts DRAIN_CYCLES cycles, then goes to PUSH_HI.
- Push sequence, one write per state:
  - Each push writes mem[sp] and then sets sp_out = sp_in − 1 with sp_wen=1.
  - Order: PUSH_HI writes ret_pc[31:16], PUSH_LO writes ret_pc[15:0], PUSH_FLG writes {13'b0, flags_in}.
- VECTOR: int_redirect=1 for one cycle, then IDLE.
- Pop sequence:
  - Each pop sets sp_out = sp_in + 1 with sp_wen=1, and reads mem[sp_in+1] with mem_re=1.
  - Order: POP_FLG (flags_wen=1, flags_out=mem_rdata[2:0]), POP_LO (latches the low half), POP_HI (latches the high half).
- RETURN: jump=1, jump_target=ret_pc for one cycle, then IDLE.
- fetch_stall=1 in DRAIN, all PUSH states and all POP states. It is 0 in IDLE, VECTOR and RETURN.
- Outputs not named for a state are 0.
- rti_req or int_req edges arriving while busy:
  - An int_req edge is still latched into pending.
  - rti_req is ignored.
  - A latched interrupt is taken from IDLE after the current sequence finishes.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE; pending, ret_pc and the drain counter clear.
  - All outputs are 0, including jump_target and mem_addr.
- Reset asserted mid-sequence abandons it. No partial restore is attempted.
- Interrupt latency, from the int_req edge to int_redirect (with imm_pending=0): 1 + 1 + DRAIN_CYCLES + 3 cycles = 8 cycles with the default.
- RTI: rti_req at cycle 0; POP_FLG at cycle 1; jump at cycle 4.
- PC halves are 16-bit words. Stack pointer arithmetic is modulo 2^32 (wraps at 0).

## Structure
- Shared package holds:
  - the state enum encoding (4 bits)
  - DRAIN_CYCLES default
  - flag bit positions {C=2, N=1, Z=0}
- One natural sub-module: int_pending_latch, holding the edge detector and the pending flag with its set and clear rules.

## Test plan
- Interrupt with no branch in flight:
  - Stimulus: fetch_pc=0x0000_0124, sp_in=0x0FFF, flags_in=3'b101, int_req rises at cycle 0.
  - Required: writes 0x0000 @0x0FFF, 0x0124 @0x0FFE, 0x0005 @0x0FFD; int_redirect at cycle 8.
- Branch during DRAIN:
  - Stimulus: ex_jump=1 with ex_target=0x0000_0300 on the second DRAIN cycle.
  - Required: pushed words are 0x0000 and 0x0300.
- Deferred entry:
  - Stimulus: imm_pending=1 for 4 cycles after pending is set.
  - Required: DRAIN starts on the cycle after imm_pending falls.
- RTI pop:
  - Stimulus: memory holds flags 0x0002, lo 0x0124, hi 0x0001 above sp_in=0x0FFC.
  - Required: flags_out=3'b010; jump_target=0x0001_0124 with jump=1 at cycle 4.
- Collisions:
  - rti_req and pending in the same IDLE cycle: RTI completes first; interrupt entry follows with the next DRAIN.
  - A second int_req edge while pending is set: no extra interrupt.
- Reset mid-push: rst=0 during PUSH_LO → all outputs 0 immediately; IDLE after release; a prior pending is lost.
